// File: rtl/s6bitserialsub_pkg.sv
// Shared types and constants for the bit-serial signed subtractor.
//   state_t       : FSM states IDLE / RUN / DONE
//   DEFAULT_WIDTH : default operand/result width
package s6bitserialsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 6;

endpackage

// File: rtl/s6bitserialsub_fulladder1bit.sv
// One-bit full adder cell, the serial bit slice of the subtractor.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module fulladder1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/s6bitserialsub.sv
// Bit-serial signed subtractor: diff = a - b, one bit per clock, computed as
// a + ~b + 1 through a single full-adder cell and a carry flop.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake for a (minuend), b (subtrahend)
//   out_valid/out_ready : result handshake for diff, overflow, borrow
//   diff                : a - b modulo 2^WIDTH
//   overflow            : signed result not representable in WIDTH bits
//   borrow              : unsigned a < b
module s6bitserialsub
  import s6bitserialsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             overflow,
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             signa;
  logic             signb;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             ovf_r;
  logic             brw_r;
  logic             fa_sum;
  logic             fa_cout;

  fulladder1bit u_fa (
    .a    (areg[0]),
    .b    (breg[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      areg        <= '0;
      breg        <= '0;
      res         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      signa       <= 1'b0;
      signb       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      brw_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            areg       <= a;
            breg       <= ~b;
            carry      <= 1'b1;
            cnt        <= '0;
            signa      <= a[WIDTH-1];
            signb      <= b[WIDTH-1];
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          res   <= {fa_sum, res[WIDTH-1:1]};
          areg  <= {1'b0, areg[WIDTH-1:1]};
          breg  <= {1'b0, breg[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // Flags are taken from the last slice directly: fa_sum is the
            // result MSB and fa_cout the final carry, both landing this edge.
            state       <= DONE;
            out_valid_r <= 1'b1;
            brw_r       <= ~fa_cout;
            ovf_r       <= (signa ^ signb) & (fa_sum ^ signa);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = res;
  assign overflow  = ovf_r;
  assign borrow    = brw_r;

endmodule

// File: tb/tb_s6bitserialsub.sv
module tb_s6bitserialsub;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         overflow;
  logic         borrow;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  s6bitserialsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .overflow  (overflow),
    .borrow    (borrow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] d, output logic o,
                                    output logic br);
    int sx, sy, sd, ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = int'(x);
    uy = int'(y);
    sd = sx - sy;
    d  = W'(ux - uy);
    o  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    br = ux < uy;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int stall);
    int g;
    int cyc;
    logic [W-1:0] ed;
    logic eo, eb;
    g = 0;
    while (!in_ready && g < 50) begin
      step();
      g++;
    end
    if (g >= 50) check("in_ready_timeout", 0, 1);
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("in_ready_low_run", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("latency", cyc, W);
    ref_model(x, y, ed, eo, eb);
    check("diff", diff, ed);
    check("overflow", overflow, eo);
    check("borrow", borrow, eb);
    repeat (stall) step();
    if (stall > 0) check("diff_hold", diff, ed);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] hd;
    logic ho, hb;
    logic [W-1:0] pa [4];
    logic [W-1:0] pb [4];
    logic [W-1:0] ed;
    logic eo, eb;
    int acc_n, res_n, last_acc, cyc;
    logic acc, tr;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_overflow", overflow, 0);
    check("rst_borrow", borrow, 0);

    // Directed boundary cases
    run_op(6'd5, 6'd3, 0);
    run_op(6'b100000, 6'd1, 1);
    run_op(6'd31, 6'b111111, 0);
    run_op(6'd3, 6'd5, 2);
    run_op(6'b100000, 6'b100000, 0);
    run_op(6'b011111, 6'b100000, 0);

    // Backpressure with an ignored in_valid
    a = 6'd20;
    b = 6'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("bp_latency", cyc, W);
    hd = diff;
    ho = overflow;
    hb = borrow;
    check("bp_diff", hd, 6'd11);
    a = 6'd1;
    b = 6'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_diff_hold", diff, hd);
      check("bp_ovf_hold", overflow, ho);
      check("bp_brw_hold", borrow, hb);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_out_valid_drop", out_valid, 0);
    check("bp_in_ready_back", in_ready, 1);
    step();
    check("bp_no_spurious_start", in_ready, 1);

    // Reset on the third RUN cycle
    a = 6'd25;
    b = 6'd4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_diff", diff, 0);
    repeat (8) begin
      step();
      check("mid_rst_no_result", out_valid, 0);
    end
    run_op(6'd7, 6'd7, 0);

    // Randomized operands and output stalls
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back with both handshakes held high
    for (int i = 0; i < 4; i++) begin
      pa[i] = W'($urandom);
      pb[i] = W'($urandom);
    end
    acc_n = 0;
    res_n = 0;
    last_acc = 0;
    cyc = 0;
    a = pa[0];
    b = pb[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (res_n < 4 && cyc < 200) begin
      acc = in_valid && in_ready;
      tr = out_valid && out_ready;
      if (tr) begin
        ref_model(pa[res_n], pb[res_n], ed, eo, eb);
        check("b2b_diff", diff, ed);
        check("b2b_overflow", overflow, eo);
        check("b2b_borrow", borrow, eb);
        check("b2b_exclusive", in_ready, 0);
        res_n++;
      end
      step();
      cyc++;
      if (acc) begin
        if (acc_n > 0) check("b2b_interval", cyc - last_acc, W + 2);
        last_acc = cyc;
        acc_n++;
        if (acc_n < 4) begin
          a = pa[acc_n];
          b = pb[acc_n];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    if (res_n < 4) check("b2b_timeout", res_n, 4);
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
